serial_adder_seq: RTL and testbench

//  Bit-serial WIDTH-bit adder/subtractor. One registered full-adder stage plus a carry flop

---
 rtl/serial_adder_seq.sv | 96 +++++++++
 tb/tb_serial_adder_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder stage and a carry flop,
// one bit per clock LSB first, with a start/busy/done handshake.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             s_bit;
  logic             carry_next;

  assign s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
  // New bit enters at the MSB end; after WIDTH shifts the LSB has reached bit 0.
  assign res_next   = WIDTH'({s_bit, res_reg} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= Sub ? ~B : B;
            carry_reg <= Sub ? 1'b1 : Cin;
            res_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= carry_next;
          res_reg   <= res_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            // carry_reg is the carry into the MSB here, carry_next the carry out of it.
            Sum       <= res_next;
            Cout      <= carry_next;
            Ovf       <= carry_reg ^ carry_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq: a WIDTH=8 instance for directed vectors
// and a WIDTH=1 instance swept over every input combination.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  serial_adder_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8)
  );

  serial_adder_seq #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  typedef struct {
    int         inst;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  bit   started = 1'b0;

  logic [7:0] m_sum [2];
  logic       m_cout[2], m_ovf[2], m_busy[2], m_done[2];
  logic [7:0] last_sum [2];
  logic       last_cout[2], last_ovf[2], prev_done[2];
  int         busy_cnt [2];

  always_comb begin
    m_sum[0] = sum8;           m_sum[1] = {7'b0, sum1};
    m_cout[0] = cout8;         m_cout[1] = cout1;
    m_ovf[0] = ovf8;           m_ovf[1] = ovf1;
    m_busy[0] = busy8;         m_busy[1] = busy1;
    m_done[0] = done8;         m_done[1] = done1;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every done pulse and polices output stability.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int w;
      w = (i == 0) ? 8 : 1;
      if (rst_seen) begin
        started = 1'b1;
        chk($sformatf("reset_state_w%0d", w),
            {20'b0, m_busy[i], m_done[i], m_cout[i], m_ovf[i], m_sum[i]}, 32'h0);
        last_sum[i] = '0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
        busy_cnt[i] = 0;  prev_done[i] = 1'b0;
      end else if (started) begin
        if (m_busy[i]) busy_cnt[i]++;
        if (m_done[i]) begin
          if (q.size() == 0 || q[0].inst != i) begin
            checks++;
            errors++;
            $display("FAIL spurious_done_w%0d actual=done required=no_done cyc=%0d", w, cyc);
          end else begin
            exp_t e;
            e = q.pop_front();
            $display("op w=%0d sum=%0h cout=%0b ovf=%0b exp_sum=%0h exp_cout=%0b exp_ovf=%0b cyc=%0d",
                     w, m_sum[i], m_cout[i], m_ovf[i], e.sum, e.cout, e.ovf, cyc);
            chk($sformatf("sum_w%0d", w), {24'b0, m_sum[i]}, {24'b0, e.sum});
            chk($sformatf("cout_w%0d", w), {31'b0, m_cout[i]}, {31'b0, e.cout});
            chk($sformatf("ovf_w%0d", w), {31'b0, m_ovf[i]}, {31'b0, e.ovf});
            chk($sformatf("latency_w%0d", w), cyc - e.acc, w);
            chk($sformatf("busy_cycles_w%0d", w), busy_cnt[i], w);
            chk($sformatf("busy_at_done_w%0d", w), {31'b0, m_busy[i]}, 32'h0);
          end
          chk($sformatf("done_one_cycle_w%0d", w), {31'b0, prev_done[i]}, 32'h0);
          busy_cnt[i]  = 0;
          last_sum[i]  = m_sum[i];
          last_cout[i] = m_cout[i];
          last_ovf[i]  = m_ovf[i];
        end else begin
          chk($sformatf("hold_w%0d", w), {22'b0, m_cout[i], m_ovf[i], m_sum[i]},
              {22'b0, last_cout[i], last_ovf[i], last_sum[i]});
        end
        prev_done[i] = m_done[i];
      end
    end
  end

  task automatic drive(input int inst, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic st);
    if (inst == 0) begin
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = st;
    end else begin
      a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; sub1 = sub; start1 = st;
    end
  endtask

  task automatic push(input int inst, input logic [7:0] es, input logic ec, input logic eo, input int acc);
    exp_t e;
    e.inst = inst; e.sum = es; e.cout = ec; e.ovf = eo; e.acc = acc;
    q.push_back(e);
  endtask

  task automatic wait_done(input int inst);
    for (int k = 0; k < 20 && !m_done[inst]; k++) @(negedge clk);
    if (!m_done[inst]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done inst=%0d cyc=%0d", inst, cyc);
    end
  endtask

  task automatic run_op(input int inst, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    drive(inst, a, b, cin, sub, 1'b1);
    @(negedge clk);
    drive(inst, a, b, cin, sub, 1'b0);
    push(inst, es, ec, eo, cyc);
    wait_done(inst);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 15 && cyc < target; k++) @(negedge clk);
  endtask

  initial begin
    int acc0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed vectors, WIDTH=8
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(0, 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    // Reset in the middle of an operation: no done may follow
    @(negedge clk);
    drive(0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);

    // start pulsed during SHIFT with other operands is ignored
    @(negedge clk);
    drive(0, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
    push(0, 8'h4B, 1'b0, 1'b0, cyc);
    repeat (2) @(negedge clk);
    drive(0, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    wait_done(0);

    // start held high: back-to-back accepts every 10 cycles, operands changed while busy
    @(negedge clk);
    drive(0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    acc0 = cyc;
    push(0, 8'h30, 1'b0, 1'b0, acc0);
    drive(0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b1);
    wait_cyc(acc0 + 10);
    push(0, 8'hA0, 1'b0, 1'b1, acc0 + 10);
    drive(0, 8'hF0, 8'h10, 1'b0, 1'b1, 1'b1);
    wait_cyc(acc0 + 20);
    push(0, 8'hE0, 1'b1, 1'b0, acc0 + 20);
    drive(0, 8'hF0, 8'h10, 1'b0, 1'b1, 1'b0);
    wait_done(0);

    // WIDTH=1 sweep over A, B, Cin, Sub
    for (int s = 0; s < 16; s++) begin
      logic a, b, cin, sub, bv, c;
      logic [1:0] tot;
      a = s[0]; b = s[1]; cin = s[2]; sub = s[3];
      bv  = sub ? ~b : b;
      c   = sub ? 1'b1 : cin;
      tot = {1'b0, a} + {1'b0, bv} + {1'b0, c};
      run_op(1, {7'b0, a}, {7'b0, b}, cin, sub, {7'b0, tot[0]}, tot[1], tot[1] ^ c);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
